tt_um_posit_mac_stream_core: RTL and testbench
==============================================

TT_UM_POSIT_MAC_STREAM_CORE -- requirements
Module: tt_um_posit_mac_stream

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; the ports are named clk and rst_n, and reset is asserted while rst_n=1 and sampled on the rising edge of clk.
REQ-002 Ports: clk in 1 (clock); rst_n in 1 (sync active-high reset); ena in 1 (enable, strobes ignored when 0); ui_in in 8 (posit8 operand byte); uio_in in 8 (control strobes, bits [3:0] used); uo_out out 8 (rounded posit8 result); uio_out out 8 (status); uio_oe out 8 (IO direction).
REQ-003 Control bits: uio_in[0]=LOAD_A; uio_in[1]=MAC; uio_in[2]=CLEAR; uio_in[3] reserved, ignored; uio_in[7:4] ignored.
REQ-004 Number format SHALL be posit<8,0> (es=0): 0x00=zero, 0x80=NaR, 0x40=1.0, 0x7F=maxpos 64, 0x01=minpos 1/64.

Function
REQ-005 LOAD_A=1 and ena=1 at a clock edge SHALL latch ui_in into operand register A.
REQ-006 MAC=1 and ena=1 at a clock edge SHALL add the exact product A*ui_in into a 32-bit signed fixed-point quire with 12 fraction bits (value = quire*2^-12).
REQ-007 Decoding SHALL take two's complement for negative inputs, set regime k from the run length, and give value ±(1.f)*2^k; products SHALL be formed exactly (a 25-bit signed magnitude fits the quire).
REQ-008 Quire addition SHALL saturate at +(2^31-1) and -(2^31) instead of wrapping.
REQ-009 If either operand of a MAC is NaR, a sticky NaR flag SHALL set and the quire SHALL remain unchanged.
REQ-010 CLEAR=1 with ena=1 SHALL zero the quire and the NaR flag; CLEAR has priority over MAC and LOAD_A in the same cycle.
REQ-011 MAC and LOAD_A together SHALL perform the MAC with the old A and ignore the load.
REQ-012 uo_out SHALL be registered: the encode of the quire updated at edge N appears after edge N+1 (one-cycle latency).
REQ-013 Encoding SHALL round to nearest, ties to even, on the posit bit pattern.
REQ-014 Encoded magnitudes above maxpos SHALL give ±maxpos; nonzero magnitudes below minpos SHALL give ±minpos; only an exact zero quire SHALL give 0x00.
REQ-015 While the NaR flag is set, uo_out SHALL be 0x80.
REQ-016 Status (when enabled): uio_out[4]=NaR flag; uio_out[5]=one-cycle DONE pulse coincident with each uo_out update caused by MAC or CLEAR; uio_out[6]=quire-is-zero; uio_out[7]=quire saturated (sticky until CLEAR); uio_out[3:0]=0.

Reset
REQ-017 Reset SHALL set A=0x00, quire=0, uo_out=0x00, all flags 0, and DONE=0.
REQ-018 Reset SHALL override all strobes in the same cycle; an operation in flight when reset is asserted is discarded.

Configuration
REQ-019 Macro POSIT_MAC_STATUS_EN: when defined, uio_oe=0xF0 and the status of REQ-016 is driven; when undefined, uio_out=0x00 and uio_oe=0x00, and arithmetic is unchanged.

Structure
REQ-020 Package posit_mac_pkg SHALL hold N=8, ES=0, QUIRE_W=32, QFRAC=12, NAR=8'h80, MAXPOS=8'h7F, MINPOS=8'h01, and a decoded-posit struct (sign, zero, nar, scale, mantissa).
REQ-021 A single sub-module posit8_decode SHALL be instantiated twice, for A and for ui_in; the multiply, accumulate and encode logic stays in the top level.

Verification
REQ-022 Identity: LOAD_A 0x40, MAC 0x40 -> uo_out 0x40 one cycle after the MAC edge, DONE pulsed.
REQ-023 Accumulate: CLEAR; LOAD_A 0x60, MAC 0x60 -> 0x70 (4.0); then LOAD_A 0x50, MAC 0x50 -> 0x74 (6.25 rounded; 4+2.25).
REQ-024 Cancellation: CLEAR; LOAD_A 0x40, MAC 0x40, MAC 0xC0 -> uo_out 0x00, zero flag 1.
REQ-025 Saturation: LOAD_A 0x7F, MAC 0x7F -> 0x7F; also LOAD_A 0x01, MAC 0x01 after CLEAR -> 0x01 (never zero).
REQ-026 NaR: MAC with ui_in 0x80 -> uo_out 0x80, uio_out[4]=1; CLEAR and MAC issued in the same cycle -> 0x00, flag 0.
REQ-027 ena=0 with strobes high -> no state change; rst_n=1 mid-stream -> all outputs 0x00 next cycle.

Source files
------------

// File: rtl/posit_mac_pkg.sv
// Shared constants and the decoded-operand type for the posit<8,0> MAC core.
package posit_mac_pkg;

  localparam int N       = 8;
  localparam int ES      = 0;
  localparam int QUIRE_W = 32;
  localparam int QFRAC   = 12;

  localparam logic [7:0] NAR    = 8'h80;
  localparam logic [7:0] MAXPOS = 8'h7F;
  localparam logic [7:0] MINPOS = 8'h01;

  // value = (-1)^sign * mantissa * 2^(scale-5); mantissa is 1.fffff, zero when the operand is 0
  typedef struct packed {
    logic       sign;
    logic       zero;
    logic       nar;
    logic [3:0] scale;
    logic [5:0] mantissa;
  } posit_dec_t;

endpackage

// File: rtl/posit8_decode.sv
// Combinational posit<8,0> decoder: sign, special cases, regime scale and 1.fffff mantissa.
module posit8_decode
  import posit_mac_pkg::*;
(
  input  logic [N-1:0] i_p,
  output posit_dec_t   o_d
);

  logic [6:0] w_mag;
  logic [4:0] w_frac;
  logic [3:0] w_run;
  logic [3:0] w_k;
  logic       w_stop;

  always_comb begin
    w_mag  = i_p[7] ? 7'(8'd0 - i_p) : i_p[6:0];
    w_run  = 4'd1;
    w_stop = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (!w_stop && (w_mag[i] == w_mag[6])) w_run = w_run + 4'd1;
      else w_stop = 1'b1;
    end
    // Regime run plus terminator occupy w_run+1 bits; what remains left-aligned is the fraction.
    w_frac = w_mag[4:0] << (w_run - 4'd1);
    w_k    = w_mag[6] ? (w_run - 4'd1) : (4'd0 - w_run);

    o_d      = '0;
    o_d.sign = i_p[7];
    o_d.zero = (i_p == '0);
    o_d.nar  = (i_p == NAR);
    if (!o_d.zero && !o_d.nar) begin
      o_d.scale    = w_k << ES;
      o_d.mantissa = {1'b1, w_frac};
    end
  end

endmodule

// File: rtl/tt_um_posit_mac_stream_core.sv
// Posit<8,0> multiply-accumulate into a saturating 32-bit quire (12 fraction bits),
// with a registered rounded posit result. Status pins are driven only when
// POSIT_MAC_STATUS_EN is defined.
module tt_um_posit_mac_stream_core
  import posit_mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [N-1:0]       r_a;
  logic [QUIRE_W-1:0] r_quire;
  logic               r_nar, r_sat, r_op_d;
  logic [N-1:0]       r_uo;
  logic               r_done, r_st_zero, r_st_nar, r_st_sat;

  logic       w_load, w_mac, w_clear;
  posit_dec_t w_da, w_db;

  assign w_load  = ena & uio_in[0];
  assign w_mac   = ena & uio_in[1];
  assign w_clear = ena & uio_in[2];

  posit8_decode u_dec_a (.i_p(r_a),   .o_d(w_da));
  posit8_decode u_dec_b (.i_p(ui_in), .o_d(w_db));

  logic [11:0]        w_pmag;
  logic [4:0]         w_ksum, w_sh;
  logic [35:0]        w_wide;
  logic [32:0]        w_term, w_sum;
  logic               w_ovf;
  logic [QUIRE_W-1:0] w_next;

  always_comb begin
    w_pmag = w_da.mantissa * w_db.mantissa;
    w_ksum = {w_da.scale[3], w_da.scale} + {w_db.scale[3], w_db.scale};
    // Product is held in 2^-22 units so every scale sum shifts left; then drop to quire units.
    w_sh   = w_ksum + 5'(QFRAC);
    w_wide = {24'd0, w_pmag} << w_sh;
    if (w_da.zero || w_db.zero)   w_term = '0;
    else if (w_da.sign ^ w_db.sign) w_term = 33'd0 - {8'd0, w_wide[34:10]};
    else                          w_term = {8'd0, w_wide[34:10]};
    w_sum  = {r_quire[QUIRE_W-1], r_quire} + w_term;
    w_ovf  = w_sum[32] ^ w_sum[31];
    if (w_ovf) w_next = w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else       w_next = w_sum[31:0];
  end

  logic [QUIRE_W-1:0] w_qmag, w_norm;
  logic [4:0]         w_msb;
  logic [3:0]         w_rlen;
  logic [39:0]        w_regime, w_ext;
  logic [6:0]         w_body;
  logic [N-1:0]       w_enc;

  always_comb begin
    w_qmag = r_quire[QUIRE_W-1] ? (32'd0 - r_quire) : r_quire;
    w_msb  = '0;
    for (int i = 0; i < QUIRE_W; i++) begin
      if (w_qmag[i]) w_msb = 5'(i);
    end
    w_norm = w_qmag << (5'd31 - w_msb);
    // Scale k = w_msb - 12; build regime + terminator at the top, fraction follows.
    if (w_msb >= 5'd12) begin
      w_rlen   = 4'(w_msb - 5'd10);
      w_regime = ~({40{1'b1}} >> (w_msb - 5'd11));
    end else begin
      w_rlen   = 4'(5'd13 - w_msb);
      w_regime = {1'b1, 39'd0} >> (5'd12 - w_msb);
    end
    w_ext  = w_regime | ({w_norm[30:0], 9'd0} >> w_rlen);
    w_body = w_ext[39:33];
    if (w_ext[32] && ((|w_ext[31:0]) || w_body[0])) w_body = w_body + 7'd1;
    if (w_msb >= 5'd18)    w_body = MAXPOS[6:0];
    else if (w_msb < 5'd6) w_body = MINPOS[6:0];
    w_enc = r_quire[QUIRE_W-1] ? (8'd0 - {1'b0, w_body}) : {1'b0, w_body};
    if (w_qmag == '0) w_enc = '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_a       <= '0;
      r_quire   <= '0;
      r_nar     <= 1'b0;
      r_sat     <= 1'b0;
      r_op_d    <= 1'b0;
      r_uo      <= '0;
      r_done    <= 1'b0;
      r_st_zero <= 1'b0;
      r_st_nar  <= 1'b0;
      r_st_sat  <= 1'b0;
    end else begin
      r_op_d <= w_clear | w_mac;
      if (w_clear) begin
        r_quire <= '0;
        r_nar   <= 1'b0;
        r_sat   <= 1'b0;
      end else if (w_mac) begin
        if (w_da.nar || w_db.nar) begin
          r_nar <= 1'b1;
        end else begin
          r_quire <= w_next;
          if (w_ovf) r_sat <= 1'b1;
        end
      end else if (w_load) begin
        r_a <= ui_in;
      end
      // Output stage lags the quire by one edge; status is aligned with it.
      r_uo      <= r_nar ? NAR : w_enc;
      r_done    <= r_op_d;
      r_st_zero <= (r_quire == '0);
      r_st_nar  <= r_nar;
      r_st_sat  <= r_sat;
    end
  end

  assign uo_out = r_uo;

  logic w_unused_bits;
  assign w_unused_bits = ^{uio_in[7:3], w_wide[35], w_wide[9:0], w_norm[31]};

`ifdef POSIT_MAC_STATUS_EN
  assign uio_out = {r_st_sat, r_st_zero, r_done, r_st_nar, 4'b0000};
  assign uio_oe  = 8'hF0;
`else
  logic w_unused_status;
  assign w_unused_status = ^{r_done, r_st_zero, r_st_nar, r_st_sat};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_posit_mac_stream_core.sv
// Bench for the posit<8,0> MAC core: value-based reference model, expected queue, directed and random scenarios.
module tb_tt_um_posit_mac_stream_core;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_posit_mac_stream_core dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];
  bit sb_on = 1'b0;

  logic [7:0] m_a;
  longint     m_q;
  bit         m_nar, m_sat;

`ifdef POSIT_MAC_STATUS_EN
  localparam logic [7:0] EXP_OE = 8'hF0;
`else
  localparam logic [7:0] EXP_OE = 8'h00;
`endif

  // Exact posit value in quire units (2^-12).
  function automatic longint pval(input logic [7:0] p);
    logic [7:0] m;
    int i, run, k, fb;
    longint frac, v;
    if (p == 8'h00) return 0;
    m = p[7] ? (8'h00 - p) : p;
    run = 0;
    i = 6;
    while (i >= 0 && m[i] == m[6]) begin
      run++;
      i--;
    end
    k = m[6] ? run - 1 : -run;
    fb = (i > 0) ? i : 0;
    frac = longint'(m) & ((longint'(1) << fb) - 1);
    v = ((longint'(1) << fb) + frac) <<< (k - fb + 12);
    return p[7] ? -v : v;
  endfunction

  // Nearest posit by searching neighbouring patterns; ties go to the even pattern.
  function automatic logic [7:0] enc(input longint q);
    longint a, lo, hi;
    logic [7:0] b;
    if (q == 0) return 8'h00;
    a = (q < 0) ? -q : q;
    b = 8'h00;
    if (a >= pval(8'h7F)) b = 8'h7F;
    else if (a <= pval(8'h01)) b = 8'h01;
    else begin
      for (int i = 1; i < 127; i++) begin
        lo = pval(8'(i));
        hi = pval(8'(i + 1));
        if (a >= lo && a < hi) begin
          if (2 * a < lo + hi) b = 8'(i);
          else if (2 * a > lo + hi) b = 8'(i + 1);
          else b = (i % 2 == 0) ? 8'(i) : 8'(i + 1);
        end
      end
    end
    return (q < 0) ? (8'h00 - b) : b;
  endfunction

  function automatic logic [W-1:0] model_out(input bit done);
    logic [7:0] uo, st;
    uo = m_nar ? 8'h80 : enc(m_q);
    st = {m_sat, (m_q == 0), done, m_nar, 4'b0000};
    return {st, uo};
  endfunction

  // Scoreboard: each cycle's outputs are compared against the oldest queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [7:0] want_st;
    if (sb_on) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty uo=%h", uo_out);
      end else begin
        e = exp_q.pop_front();
`ifdef POSIT_MAC_STATUS_EN
        want_st = e[15:8];
`else
        want_st = 8'h00;
`endif
        if ({uio_out, uo_out} !== {want_st, e[7:0]}) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t uo=%h status=%h want uo=%h status=%h",
                   $time, uo_out, uio_out, e[7:0], want_st);
        end
      end
    end
  end

  task automatic drive_cycle(input bit en, input bit ld, input bit mc, input bit cl,
                             input logic [7:0] d);
    longint s;
    bit done;
    ena    = en;
    ui_in  = d;
    uio_in = {4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), cl, mc, ld};
    @(posedge clk);
    #1;
    done = 1'b0;
    if (en) begin
      if (cl) begin
        m_q = 0; m_nar = 1'b0; m_sat = 1'b0; done = 1'b1;
      end else if (mc) begin
        done = 1'b1;
        if (m_a == 8'h80 || d == 8'h80) m_nar = 1'b1;
        else begin
          s = m_q + (pval(m_a) * pval(d)) / 4096;
          if (s > 64'sd2147483647) begin s = 64'sd2147483647; m_sat = 1'b1; end
          if (s < -64'sd2147483648) begin s = -64'sd2147483648; m_sat = 1'b1; end
          m_q = s;
        end
      end else if (ld) begin
        m_a = d;
      end
    end
    exp_q.push_back(model_out(done));
  endtask

  task automatic test_reset(input bit strobes);
    sb_on  = 1'b0;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h7F;
    uio_in = strobes ? 8'h07 : 8'h00;
    @(posedge clk);
    #1;
    n_total++;
    if (uo_out !== 8'h00) begin n_bad++; $display("FAIL reset_uo got=%h want=00", uo_out); end
    n_total++;
    if (uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_status got=%h want=00", uio_out); end
    n_total++;
    if (uio_oe !== EXP_OE) begin n_bad++; $display("FAIL reset_oe got=%h want=%h", uio_oe, EXP_OE); end
    rst_n = 1'b0; ena = 1'b0; uio_in = 8'h00;
    m_a = 8'h00; m_q = 0; m_nar = 1'b0; m_sat = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back(model_out(1'b0));
    sb_on = 1'b1;
  endtask

  task automatic test_identity();
    drive_cycle(1, 1, 0, 0, 8'h40);
    drive_cycle(1, 0, 1, 0, 8'h40);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h40) begin n_bad++; $display("FAIL identity got=%h want=40", uo_out); end
`ifdef POSIT_MAC_STATUS_EN
    n_total++;
    if (uio_out[5] !== 1'b1) begin n_bad++; $display("FAIL identity_done got=%b want=1", uio_out[5]); end
`endif
  endtask

  task automatic test_accumulate();
    drive_cycle(1, 0, 0, 1, 8'h00);
    drive_cycle(1, 1, 0, 0, 8'h60);
    drive_cycle(1, 0, 1, 0, 8'h60);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h70) begin n_bad++; $display("FAIL accum_4 got=%h want=70", uo_out); end
    drive_cycle(1, 1, 0, 0, 8'h50);
    drive_cycle(1, 0, 1, 0, 8'h50);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h74) begin n_bad++; $display("FAIL accum_6p25 got=%h want=74", uo_out); end
  endtask

  task automatic test_cancel();
    drive_cycle(1, 0, 0, 1, 8'h00);
    drive_cycle(1, 1, 0, 0, 8'h40);
    drive_cycle(1, 0, 1, 0, 8'h40);
    drive_cycle(1, 0, 1, 0, 8'hC0);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h00) begin n_bad++; $display("FAIL cancel got=%h want=00", uo_out); end
`ifdef POSIT_MAC_STATUS_EN
    n_total++;
    if (uio_out[6] !== 1'b1) begin n_bad++; $display("FAIL cancel_zero got=%b want=1", uio_out[6]); end
`endif
  endtask

  task automatic test_saturation();
    drive_cycle(1, 0, 0, 1, 8'h00);
    drive_cycle(1, 1, 0, 0, 8'h7F);
    drive_cycle(1, 0, 1, 0, 8'h7F);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h7F) begin n_bad++; $display("FAIL maxpos got=%h want=7f", uo_out); end
    drive_cycle(1, 0, 0, 1, 8'h00);
    drive_cycle(1, 1, 0, 0, 8'h01);
    drive_cycle(1, 0, 1, 0, 8'h01);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h01) begin n_bad++; $display("FAIL minpos got=%h want=01", uo_out); end
    drive_cycle(1, 0, 0, 1, 8'h00);
    drive_cycle(1, 1, 0, 0, 8'h7F);
    for (int i = 0; i < 130; i++) drive_cycle(1, 0, 1, 0, 8'h7F);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h7F) begin n_bad++; $display("FAIL sat_pos got=%h want=7f", uo_out); end
`ifdef POSIT_MAC_STATUS_EN
    n_total++;
    if (uio_out[7] !== 1'b1) begin n_bad++; $display("FAIL sat_flag got=%b want=1", uio_out[7]); end
`endif
    drive_cycle(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 130; i++) drive_cycle(1, 0, 1, 0, 8'h81);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h81) begin n_bad++; $display("FAIL sat_neg got=%h want=81", uo_out); end
  endtask

  task automatic test_nar();
    drive_cycle(1, 0, 0, 1, 8'h00);
    drive_cycle(1, 1, 0, 0, 8'h40);
    drive_cycle(1, 0, 1, 0, 8'h80);
    drive_cycle(1, 0, 1, 0, 8'h40);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h80) begin n_bad++; $display("FAIL nar got=%h want=80", uo_out); end
`ifdef POSIT_MAC_STATUS_EN
    n_total++;
    if (uio_out[4] !== 1'b1) begin n_bad++; $display("FAIL nar_flag got=%b want=1", uio_out[4]); end
`endif
    drive_cycle(1, 0, 1, 1, 8'h40);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h00) begin n_bad++; $display("FAIL nar_clear got=%h want=00", uo_out); end
`ifdef POSIT_MAC_STATUS_EN
    n_total++;
    if (uio_out[4] !== 1'b0) begin n_bad++; $display("FAIL nar_flag_clear got=%b want=0", uio_out[4]); end
`endif
  endtask

  task automatic test_load_mac_priority();
    drive_cycle(1, 0, 0, 1, 8'h00);
    drive_cycle(1, 1, 0, 0, 8'h40);
    drive_cycle(1, 1, 1, 0, 8'h60);
    drive_cycle(1, 0, 1, 0, 8'h40);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h68) begin n_bad++; $display("FAIL load_mac got=%h want=68", uo_out); end
  endtask

  task automatic test_ena_low();
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 1, 1, 8'h7F);
    drive_cycle(1, 0, 0, 0, 8'h00);
    n_total++;
    if (uo_out !== 8'h68) begin n_bad++; $display("FAIL ena_low got=%h want=68", uo_out); end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1, 0, 0, 1, 8'h00);
    drive_cycle(1, 1, 0, 0, 8'($urandom_range(1, 127)));
    for (int i = 0; i < 24; i++) drive_cycle(1, 0, 1, 0, 8'($urandom_range(0, 255)));
    drive_cycle(1, 0, 0, 0, 8'h00);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      drive_cycle(($urandom_range(0, 7) != 0), (r >= 1 && r <= 3) || r == 9,
                  (r >= 4), (r == 0), 8'($urandom_range(0, 255)));
    end
    drive_cycle(1, 0, 0, 0, 8'h00);
  endtask

  task automatic test_midstream_reset();
    drive_cycle(1, 1, 0, 0, 8'h60);
    drive_cycle(1, 0, 1, 0, 8'h60);
    drive_cycle(1, 0, 1, 0, 8'h60);
    test_reset(1'b1);
    test_identity();
  endtask

  initial begin
    test_reset(1'b0);
    test_identity();
    test_accumulate();
    test_cancel();
    test_saturation();
    test_nar();
    test_load_mac_priority();
    test_ena_low();
    test_back_to_back();
    test_random();
    test_midstream_reset();
    drive_cycle(1, 0, 0, 0, 8'h00);
    drive_cycle(1, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    sb_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
